decoder_scan: RTL and testbench

Parametrised, registered IN_W-to-2^IN_W one-hot decoder with two modes: direct decode of a handshaked input code, and an autonomous scan that sweeps every output line in turn with a programmable dwell time. It generalises the combinational 4-to-16 decoder into a clocked block with configurable width and output polarity, enable/abort control, and a completion pulse. Intended users are row/column select drivers and self-test sweeps of downstream one-hot consumers.

---
 rtl/decoder_scan.sv | 137 +++++++++++++
 tb/tb_decoder_scan.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan.sv
// decoder_scan: registered IN_W-to-2^IN_W one-hot decoder.
// Direct mode decodes a handshaked code. Scan mode sweeps every output line in
// ascending order, holding each one for dwell+1 cycles, then pulses done.
module decoder_scan #(
    parameter int IN_W        = 4,
    parameter int DWELL_W     = 8,
    parameter bit OUT_ACT_LOW = 1'b0,
    localparam int OUT_W      = 1 << IN_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode,
    input  logic [IN_W-1:0]    din,
    input  logic               din_valid,
    input  logic               start,
    input  logic [DWELL_W-1:0] dwell,
    output logic [OUT_W-1:0]   dout,
    output logic               dout_valid,
    output logic [IN_W-1:0]    idx,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } state_t;

    // Idle pattern: all zeros for active-high lines, all ones for active-low.
    localparam logic [OUT_W-1:0] INACTIVE = {OUT_W{OUT_ACT_LOW}};
    localparam logic [IN_W-1:0]  LAST_IDX = {IN_W{1'b1}};

    state_t             r_state;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] r_cnt;
    logic [IN_W-1:0]    r_idx;
    logic [OUT_W-1:0]   r_dout;
    logic               r_valid;
    logic               r_busy;
    logic               r_done;

    logic [IN_W-1:0]    w_next_idx;
    logic               w_scan_req;
    logic               w_dir_req;

    // Line pattern for code k; XOR with the idle pattern applies the polarity.
    function automatic logic [OUT_W-1:0] f_code(input logic [IN_W-1:0] k);
        logic [OUT_W-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v ^ INACTIVE;
    endfunction

    assign w_next_idx = r_idx + 1'b1;
    // mode picks which strobe counts; the other strobe is ignored.
    assign w_scan_req = mode & start;
    assign w_dir_req  = ~mode & din_valid;

    // Control FSM with every output registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_dwell <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_dout  <= INACTIVE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees
            // pre-edge values; the pulses default low and only the branches
            // that fire them override the default.
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            if (!en) begin
                // Disable aborts silently: no done, no dout_valid.
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_idx   <= '0;
                r_dout  <= INACTIVE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_scan_req) begin
                            r_dwell <= dwell;
                            r_cnt   <= dwell;
                            r_idx   <= '0;
                            r_dout  <= f_code('0);
                            r_valid <= 1'b1;
                            r_busy  <= 1'b1;
                            r_state <= ST_SCAN;
                        end else if (w_dir_req) begin
                            r_idx   <= din;
                            r_dout  <= f_code(din);
                            r_valid <= 1'b1;
                        end
                    end
                    ST_SCAN: begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - 1'b1;
                        end else if (r_idx != LAST_IDX) begin
                            r_idx   <= w_next_idx;
                            r_dout  <= f_code(w_next_idx);
                            r_valid <= 1'b1;
                            r_cnt   <= r_dwell;
                        end else begin
                            // Last line has served its dwell: finish the sweep.
                            r_idx   <= '0;
                            r_dout  <= INACTIVE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        // One-cycle gap: strobes are not accepted here.
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_valid;
    assign idx        = r_idx;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_decoder_scan.sv
// tb_decoder_scan: drives a default decoder_scan (IN_W=4, active-high) and a
// corner instance (IN_W=3, active-low) with shared stimulus. A schedule-based
// reference model predicts every output on every cycle.
module tb_decoder_scan;

    logic        clk;
    logic        rst;
    logic        en;
    logic        mode;
    logic [3:0]  din;
    logic [2:0]  din1;
    logic        din_valid;
    logic        start;
    logic [7:0]  dwell;

    logic [15:0] dout0;
    logic        dout_valid0;
    logic [3:0]  idx0;
    logic        busy0;
    logic        done0;

    logic [7:0]  dout1;
    logic        dout_valid1;
    logic [2:0]  idx1;
    logic        busy1;
    logic        done1;

    int n_checks = 0;
    int n_fail   = 0;

    int n_valid0, n_busy0, n_done0;
    int n_valid1, n_busy1, n_done1;

    assign din1 = din[2:0];

    decoder_scan u_dut0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .din(din), .din_valid(din_valid), .start(start), .dwell(dwell),
        .dout(dout0), .dout_valid(dout_valid0), .idx(idx0),
        .busy(busy0), .done(done0)
    );

    decoder_scan #(.IN_W(3), .DWELL_W(8), .OUT_ACT_LOW(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .din(din1), .din_valid(din_valid), .start(start), .dwell(dwell),
        .dout(dout1), .dout_valid(dout_valid1), .idx(idx1),
        .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Each instance's future outputs are a precomputed per-cycle schedule:
    // a scan start pushes dwell+1 entries per code, then a done cycle and
    // a one-cycle gap in which strobes are not accepted.
    typedef struct packed {
        logic [15:0] dout;
        logic [3:0]  idx;
        logic        valid;
        logic        busy;
        logic        done;
    } obs_t;

    obs_t exp_s [2];
    obs_t q0[$];
    obs_t q1[$];

    function automatic logic [15:0] inact(input int m);
        return (m == 0) ? 16'h0000 : 16'h00FF;
    endfunction

    function automatic logic [15:0] code_of(input int m, input int k);
        logic [15:0] one;
        one = 16'd1 << k;
        return (m == 0) ? one : (~one & 16'h00FF);
    endfunction

    function automatic obs_t mk(input logic [15:0] d, input logic [3:0] i,
                                input logic v, input logic b, input logic dn);
        obs_t o;
        o.dout = d; o.idx = i; o.valid = v; o.busy = b; o.done = dn;
        return o;
    endfunction

    function automatic int q_size(input int m);
        return (m == 0) ? q0.size() : q1.size();
    endfunction

    task automatic q_push(input int m, input obs_t e);
        if (m == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic q_pop(input int m, output obs_t e);
        if (m == 0) e = q0.pop_front();
        else        e = q1.pop_front();
    endtask

    task automatic q_clear(input int m);
        if (m == 0) q0.delete();
        else        q1.delete();
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            q_clear(m);
            exp_s[m] = mk(inact(m), 4'd0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic model_edge(input int m);
        obs_t       nx;
        int         n_codes;
        logic [3:0] d;
        n_codes  = (m == 0) ? 16 : 8;
        d        = (m == 0) ? din : {1'b0, din[2:0]};
        nx       = exp_s[m];
        nx.valid = 1'b0;
        nx.done  = 1'b0;
        if (!en) begin
            q_clear(m);
            nx = mk(inact(m), 4'd0, 1'b0, 1'b0, 1'b0);
        end else if (q_size(m) > 0) begin
            q_pop(m, nx);
        end else if (mode && start) begin
            for (int k = 0; k < n_codes; k++)
                for (int r = 0; r <= int'(dwell); r++)
                    q_push(m, mk(code_of(m, k), 4'(k), r == 0, 1'b1, 1'b0));
            q_push(m, mk(inact(m), 4'd0, 1'b0, 1'b0, 1'b1));
            q_push(m, mk(inact(m), 4'd0, 1'b0, 1'b0, 1'b0));
            q_pop(m, nx);
        end else if (!mode && din_valid) begin
            nx = mk(code_of(m, int'(d)), d, 1'b1, 1'b0, 1'b0);
        end
        exp_s[m] = nx;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("dout0",  32'(dout0),       32'(exp_s[0].dout));
        check("idx0",   32'(idx0),        32'(exp_s[0].idx));
        check("valid0", 32'(dout_valid0), 32'(exp_s[0].valid));
        check("busy0",  32'(busy0),       32'(exp_s[0].busy));
        check("done0",  32'(done0),       32'(exp_s[0].done));
        check("dout1",  32'(dout1),       32'(exp_s[1].dout));
        check("idx1",   32'(idx1),        32'(exp_s[1].idx));
        check("valid1", 32'(dout_valid1), 32'(exp_s[1].valid));
        check("busy1",  32'(busy1),       32'(exp_s[1].busy));
        check("done1",  32'(done1),       32'(exp_s[1].done));
    endtask

    task automatic clr_cnt();
        n_valid0 = 0; n_busy0 = 0; n_done0 = 0;
        n_valid1 = 0; n_busy1 = 0; n_done1 = 0;
    endtask

    // One clock: update the model at the edge, sample #1 later, compare.
    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else begin
            model_edge(0);
            model_edge(1);
        end
        #1;
        compare_all();
        if (dout_valid0) n_valid0++;
        if (busy0)       n_busy0++;
        if (done0)       n_done0++;
        if (dout_valid1) n_valid1++;
        if (busy1)       n_busy1++;
        if (done1)       n_done1++;
    endtask

    task automatic idle_inputs();
        mode = 1'b0; start = 1'b0; din_valid = 1'b0; din = '0; dwell = '0;
    endtask

    task automatic check_reset_values();
        check("rst_dout0",  32'(dout0),       32'h0000);
        check("rst_idx0",   32'(idx0),        32'h0);
        check("rst_busy0",  32'(busy0),       32'h0);
        check("rst_done0",  32'(done0),       32'h0);
        check("rst_valid0", 32'(dout_valid0), 32'h0);
        check("rst_dout1",  32'(dout1),       32'h00FF);
        check("rst_busy1",  32'(busy1),       32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        en  = 1'b0;
        idle_inputs();
        clr_cnt();
        model_reset();

        // Reset is asynchronous: values must appear without a clock edge.
        #2 rst = 1'b1;
        #1 check_reset_values();
        step();
        step();
        rst = 1'b0;

        // Direct sweep 0..15, one request per cycle.
        en = 1'b1;
        clr_cnt();
        for (int i = 0; i < 16; i++) begin
            din_valid = 1'b1;
            din       = 4'(i);
            step();
        end
        idle_inputs();
        step();
        check("sweep_final_dout0", 32'(dout0), 32'h8000);
        check("sweep_valid_cnt0",  32'(n_valid0), 32'd16);

        // Same code twice in a row still pulses; active-low corner decode.
        din_valid = 1'b1; din = 4'd3;
        step();
        step();
        check("direct3_dout1", 32'(dout1), 32'hF7);
        check("direct3_dout0", 32'(dout0), 32'h0008);
        idle_inputs();
        step();

        // Scan, dwell=0.
        clr_cnt();
        mode = 1'b1; start = 1'b1; dwell = 8'd0;
        step();
        start = 1'b0;
        for (int i = 0; i < 19; i++) step();
        check("scan0_busy_cnt0",  32'(n_busy0),  32'd16);
        check("scan0_done_cnt0",  32'(n_done0),  32'd1);
        check("scan0_valid_cnt0", 32'(n_valid0), 32'd16);
        check("scan0_busy_cnt1",  32'(n_busy1),  32'd8);
        check("scan0_end_dout0",  32'(dout0),    32'h0000);

        // Scan, dwell=2, with strobe/mode/dwell noise during the sweep.
        clr_cnt();
        mode = 1'b1; start = 1'b1; dwell = 8'd2;
        step();
        for (int i = 0; i < 54; i++) begin
            if (i < 45) begin
                start     = 1'($urandom);
                din_valid = 1'($urandom);
                mode      = 1'($urandom);
                din       = 4'($urandom);
                dwell     = 8'($urandom_range(0, 3));
            end else begin
                idle_inputs();
            end
            step();
        end
        check("scan2_busy_cnt0",  32'(n_busy0),  32'd48);
        check("scan2_valid_cnt0", 32'(n_valid0), 32'd16);
        check("scan2_done_cnt0",  32'(n_done0),  32'd1);

        // Disable to flush everything, then a dwell=1 scan.
        idle_inputs();
        en = 1'b0;
        step();
        step();
        check("idle_dout1", 32'(dout1), 32'hFF);
        en = 1'b1;
        clr_cnt();
        mode = 1'b1; start = 1'b1; dwell = 8'd1;
        step();
        start = 1'b0;
        for (int i = 0; i < 35; i++) step();
        check("scan1_busy_cnt1",  32'(n_busy1), 32'd16);
        check("scan1_done_cnt1",  32'(n_done1), 32'd1);
        check("scan1_busy_cnt0",  32'(n_busy0), 32'd32);

        // Abort with en=0 at idx=5: no done pulse afterwards.
        mode = 1'b1; start = 1'b1; dwell = 8'd0;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("abort_idx0", 32'(idx0), 32'd5);
        en = 1'b0;
        clr_cnt();
        step();
        check("abort_dout0", 32'(dout0), 32'h0000);
        check("abort_busy0", 32'(busy0), 32'h0);
        en = 1'b1;
        idle_inputs();
        for (int i = 0; i < 20; i++) step();
        check("abort_no_done0", 32'(n_done0), 32'd0);
        check("abort_no_valid0", 32'(n_valid0), 32'd0);

        // Reset mid-scan at idx=9, then a fresh scan from code 0.
        mode = 1'b1; start = 1'b1; dwell = 8'd0;
        step();
        start = 1'b0;
        for (int i = 0; i < 9; i++) step();
        check("midrst_idx0", 32'(idx0), 32'd9);
        #3 rst = 1'b1;
        #1 check_reset_values();
        model_reset();
        step();
        rst = 1'b0;
        mode = 1'b1; start = 1'b1; dwell = 8'd0;
        step();
        check("restart_dout0", 32'(dout0), 32'h0001);
        check("restart_busy0", 32'(busy0), 32'h1);
        start = 1'b0;
        for (int i = 0; i < 20; i++) step();

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            en        = ($urandom_range(0, 15) != 0);
            mode      = 1'($urandom);
            start     = 1'($urandom);
            din_valid = 1'($urandom);
            din       = 4'($urandom);
            dwell     = 8'($urandom_range(0, 3));
            step();
        end

        // Both strobes with mode=0: direct decode only, no scan.
        idle_inputs();
        en = 1'b0;
        step();
        en = 1'b1;
        step();
        mode = 1'b0; start = 1'b1; din_valid = 1'b1; din = 4'd6;
        step();
        check("both_busy0", 32'(busy0), 32'h0);
        check("both_dout0", 32'(dout0), 32'h0040);
        check("both_dout1", 32'(dout1), 32'hBF);
        idle_inputs();
        for (int i = 0; i < 3; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
